axis_stream_rx_fifo: RTL and testbench
======================================

Name: axis_stream_rx_fifo

Overview:
- AXI-Stream slave stage that sits directly downstream of the stream master and consumes its tdata/tstrb/tkeep/tlast/TID/TDEST/TUSER beats.
- Classifies each accepted beat, drops null and misrouted beats, and buffers the rest in a show-ahead FIFO.
- Presents buffered beats on a local valid/ready read port.
- Tracks packet framing, counts completed packets and flags protocol errors for the testbench/consumer.

Parameters:
- n, 4, tdata width in bytes (tdata = 8*n bits, tstrb/tkeep = n bits).
- DEPTH, 8, FIFO entries; power of two, >= 2.
- MY_DEST, 1, TDEST value this stage owns; other TDEST beats are accepted and discarded.

Ports:
- aclk  in  1  clock; all logic on rising edge.
- areset  in  1  synchronous, active-high reset.
- tvalid  in  1  stream beat valid.
- tready  out  1  stage can accept a beat.
- tdata  in  8*n  stream data.
- tstrb  in  n  byte strobe.
- tkeep  in  n  byte keep.
- tlast  in  1  packet boundary.
- TID  in  1  stream ID.
- TDEST  in  1  routing destination.
- TUSER  in  1  sideband, stored with beat.
- rd_valid  out  1  FIFO head valid.
- rd_ready  in  1  consumer pops head when rd_valid && rd_ready.
- rd_data  out  8*n  head data.
- rd_strb  out  n  head tstrb.
- rd_keep  out  n  head tkeep.
- rd_last  out  1  head tlast.
- rd_user  out  1  head TUSER.
- fill  out  $clog2(DEPTH)+1  occupancy.
- pkt_count  out  16  packets fully accepted (wraps 0xFFFF->0).
- drop_count  out  16  beats discarded (wraps).
- proto_err  out  1  sticky protocol error.

Behaviour:
- Reset (areset=1 at posedge): FIFO flushed, fill=0, rd_valid=0, rd_* outputs=0, pkt_count=0, drop_count=0, proto_err=0, FSM=IDLE.
- tready = !areset && (fill != DEPTH). It is combinational from registered fill only. There is no full-bypass: when full, tready stays 0 even if a pop happens the same cycle.
- Accept = tvalid && tready. tdata/tstrb/tkeep/tlast/TUSER are sampled on the same edge.
- Beat classification on accept:
  - Store if TDEST==MY_DEST && (tkeep!=0 || tlast).
  - Drop (drop_count+1) if TDEST!=MY_DEST, or if tkeep==0 && !tlast (null beat).
  - A null beat with tlast=1 is stored so the packet boundary survives.
- Reserved byte: any byte i with tkeep[i]=0 && tstrb[i]=1 in an accepted beat sets proto_err. The beat is still handled per the classification rules above.
- Framing FSM, updated on accepted beats with TDEST==MY_DEST:
  - IDLE: tlast=0 -> IN_PKT, latch TID. tlast=1 -> stay IDLE, pkt_count+1 (single-beat packet).
  - IN_PKT: TID differs from the latched TID -> proto_err. tlast=1 -> IDLE, pkt_count+1. tlast=0 -> stay.
  - Misrouted beats do not affect the FSM.
- FIFO is show-ahead:
  - A stored beat appears on rd_* with rd_valid=1 the cycle after accept (latency 1) when the FIFO was empty.
  - rd_* stay stable while rd_valid && !rd_ready.
  - Pop advances the head on the same edge.
- Simultaneous push and pop: fill unchanged, pointers both advance. Valid at any non-empty fill.
- Pop when empty: ignored.
- Pointers wrap modulo DEPTH. fill distinguishes full from empty.
- Counters wrap silently.
- proto_err clears only on areset.
- Reset mid-packet or with FIFO non-empty: all contents discarded, with no partial output.
- Upstream holding tvalid with tready=0 is legal. No state changes until accept.

Decomposition:
- Shared package axis_pkg holds:
  - byte-class enum (NULL, POSITION, DATA, RESERVED from tkeep/tstrb pairs);
  - framing FSM enum (IDLE, IN_PKT);
  - beat struct (data, strb, keep, last, user), parameterised by n via localparam.
- One sub-module, axis_sync_fifo: generic show-ahead synchronous FIFO, DEPTH x beat-struct, with push/pop/fill and synchronous active-high reset.
- Classification and the FSM live in the top.

Test Plan:
- Single packet: 3 beats, TDEST=1, tkeep=tstrb=4'hF, data 0x11111111/0x22222222/0x33333333, last on 3rd, rd_ready=1.
  -> rd_data in order, each 1 cycle after accept, rd_last on 0x33333333, pkt_count=1, drop_count=0.
- Backpressure/full: rd_ready=0, push 9 beats with DEPTH=8.
  -> tready=0 after 8th accept, fill=8, 9th beat held. Then a 1-cycle rd_ready pulse -> fill=7, tready=1 the next cycle, 9th beat accepted.
- Filtering: null beat (tkeep=0, tlast=0), then misrouted beat (TDEST=0), then null beat with tlast=1.
  -> drop_count=2, only the last beat stored with rd_keep=0 and rd_last=1, pkt_count=1.
- Protocol errors: beat with tkeep=4'h0, tstrb=4'h1 -> proto_err=1 next cycle. Separately, a TID flip mid-packet -> proto_err=1, stays 1 until areset.
- Simultaneous push/pop at fill=4 for 10 cycles -> fill stays 4, data order preserved across pointer wrap.
- Reset mid-packet: areset for 1 cycle with FSM=IN_PKT and fill=5.
  -> next cycle fill=0, rd_valid=0, counters 0, FSM=IDLE. A following 1-beat tlast packet gives pkt_count=1.

Source files
------------

// File: rtl/axis_pkg.sv
// Shared types for the AXI-Stream receive FIFO: byte classes, framing states
// and the beat record stored in the FIFO.
package axis_pkg;

   localparam int AXIS_N = 4;

   // Encoded as {tkeep bit, tstrb bit} so the class falls straight out of the pair
   typedef enum logic [1:0] {
      BC_NULL     = 2'b00,
      BC_RESERVED = 2'b01,
      BC_POSITION = 2'b10,
      BC_DATA     = 2'b11
   } byte_class_e;

   typedef enum logic {
      ST_IDLE,
      ST_IN_PKT
   } frame_state_e;

   typedef struct packed {
      logic [8*AXIS_N-1:0] data;
      logic [AXIS_N-1:0]   strb;
      logic [AXIS_N-1:0]   keep;
      logic                last;
      logic                user;
   } beat_t;

   function automatic byte_class_e classify_byte(input logic keep, input logic strb);
      return byte_class_e'({keep, strb});
   endfunction

endpackage

// File: rtl/axis_stream_rx_fifo_if.sv
// Stream input and local read port of the receive FIFO, bundled for connection.
interface axis_stream_rx_fifo_if #(
   parameter int n = 4
) ();

   logic           tvalid;
   logic           tready;
   logic [8*n-1:0] tdata;
   logic [n-1:0]   tstrb;
   logic [n-1:0]   tkeep;
   logic           tlast;
   logic           TID;
   logic           TDEST;
   logic           TUSER;

   logic           rd_valid;
   logic           rd_ready;
   logic [8*n-1:0] rd_data;
   logic [n-1:0]   rd_strb;
   logic [n-1:0]   rd_keep;
   logic           rd_last;
   logic           rd_user;

   modport master (
      output tvalid, tdata, tstrb, tkeep, tlast, TID, TDEST, TUSER,
      input  tready,
      input  rd_valid, rd_data, rd_strb, rd_keep, rd_last, rd_user,
      output rd_ready
   );

   modport slave (
      input  tvalid, tdata, tstrb, tkeep, tlast, TID, TDEST, TUSER,
      output tready,
      output rd_valid, rd_data, rd_strb, rd_keep, rd_last, rd_user,
      input  rd_ready
   );

endinterface

// File: rtl/axis_sync_fifo.sv
// Show-ahead synchronous FIFO of beat records; the head is visible whenever
// the FIFO is non-empty and reads as zero otherwise.
module axis_sync_fifo
   import axis_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                     aclk,
   input  logic                     areset,
   input  logic                     push,
   input  beat_t                    din,
   input  logic                     pop,
   output beat_t                    dout,
   output logic                     dout_vld,
   output logic [$clog2(DEPTH):0]   fill
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   beat_t          mem [DEPTH];
   logic [AW-1:0]  wr_ptr;
   logic [AW-1:0]  rd_ptr;
   logic           do_push;
   logic           do_pop;

   assign do_push = push && (fill != FULL);
   assign do_pop  = pop && (fill != '0);

   // Pointers wrap naturally at the power-of-two depth; fill separates full from empty
   always_ff @(posedge aclk) begin
      if (areset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         fill   <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   fill <= fill + (AW+1)'(1);
            2'b01:   fill <= fill - (AW+1)'(1);
            default: fill <= fill;
         endcase
      end
   end

   always_ff @(posedge aclk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   assign dout_vld = (fill != '0);
   assign dout     = dout_vld ? mem[rd_ptr] : '0;

endmodule

// File: rtl/axis_stream_rx_fifo.sv
// AXI-Stream receive stage: classifies and filters beats, tracks packet framing,
// and buffers routed beats in a show-ahead FIFO read through a valid/ready port.
module axis_stream_rx_fifo
   import axis_pkg::*;
#(
   parameter int n       = AXIS_N,
   parameter int DEPTH   = 8,
   parameter bit MY_DEST = 1'b1
) (
   input  logic                     aclk,
   input  logic                     areset,
   axis_stream_rx_fifo_if.slave     s,
   output logic [$clog2(DEPTH):0]   fill,
   output logic [15:0]              pkt_count,
   output logic [15:0]              drop_count,
   output logic                     proto_err
);

   localparam logic [$clog2(DEPTH):0] FULL = ($clog2(DEPTH)+1)'(DEPTH);

   function automatic logic has_reserved(input logic [n-1:0] keep, input logic [n-1:0] strb);
      logic r;
      r = 1'b0;
      for (int i = 0; i < n; i++) begin
         if (classify_byte(keep[i], strb[i]) == BC_RESERVED) r = 1'b1;
      end
      return r;
   endfunction

   logic          accept;
   logic          for_me;
   logic          store;
   logic          drop;
   logic          reserved;
   beat_t         wr_beat;
   beat_t         head;
   logic          head_vld;

   frame_state_e  state;
   frame_state_e  state_nxt;
   logic          tid_q;
   logic          fsm_step;
   logic          pkt_inc;
   logic          tid_err;
   logic          tid_latch;

   // No full-bypass: a pop in the same cycle does not open tready
   assign s.tready = !areset && (fill != FULL);

   assign accept   = s.tvalid && s.tready;
   assign for_me   = (s.TDEST == MY_DEST);
   assign store    = accept && for_me && ((|s.tkeep) || s.tlast);
   assign drop     = accept && !store;
   assign reserved = has_reserved(s.tkeep, s.tstrb);
   assign fsm_step = accept && for_me;

   always_comb begin
      wr_beat      = '0;
      wr_beat.data = s.tdata;
      wr_beat.strb = s.tstrb;
      wr_beat.keep = s.tkeep;
      wr_beat.last = s.tlast;
      wr_beat.user = s.TUSER;
   end

   always_ff @(posedge aclk) begin
      if (areset) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (fsm_step && !s.tlast) state_nxt = ST_IN_PKT;
         ST_IN_PKT: if (fsm_step && s.tlast)  state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      pkt_inc   = 1'b0;
      tid_err   = 1'b0;
      tid_latch = 1'b0;
      if (fsm_step) begin
         pkt_inc   = s.tlast;
         tid_err   = (state == ST_IN_PKT) && (s.TID != tid_q);
         tid_latch = (state == ST_IDLE) && !s.tlast;
      end
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         pkt_count  <= '0;
         drop_count <= '0;
         proto_err  <= 1'b0;
         tid_q      <= 1'b0;
      end else begin
         if (pkt_inc)   pkt_count  <= pkt_count + 16'd1;
         if (drop)      drop_count <= drop_count + 16'd1;
         if ((accept && reserved) || tid_err) proto_err <= 1'b1;
         if (tid_latch) tid_q      <= s.TID;
      end
   end

   axis_sync_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .aclk     (aclk),
      .areset   (areset),
      .push     (store),
      .din      (wr_beat),
      .pop      (s.rd_ready),
      .dout     (head),
      .dout_vld (head_vld),
      .fill     (fill)
   );

   assign s.rd_valid = head_vld;
   assign s.rd_data  = head.data;
   assign s.rd_strb  = head.strb;
   assign s.rd_keep  = head.keep;
   assign s.rd_last  = head.last;
   assign s.rd_user  = head.user;

endmodule

// File: tb/tb_axis_stream_rx_fifo.sv
// Scoreboard bench for axis_stream_rx_fifo: directed scenarios plus random traffic
// against a queue-based reference model.
module tb_axis_stream_rx_fifo;

   localparam int N       = 4;
   localparam int DEPTH   = 8;
   localparam bit MY_DEST = 1'b1;

   logic        aclk = 1'b0;
   logic        areset = 1'b1;
   logic [3:0]  fill;
   logic [15:0] pkt_count;
   logic [15:0] drop_count;
   logic        proto_err;

   axis_stream_rx_fifo_if #(.n(N)) bus ();

   axis_stream_rx_fifo #(
      .n       (N),
      .DEPTH   (DEPTH),
      .MY_DEST (MY_DEST)
   ) dut (
      .aclk       (aclk),
      .areset     (areset),
      .s          (bus),
      .fill       (fill),
      .pkt_count  (pkt_count),
      .drop_count (drop_count),
      .proto_err  (proto_err)
   );

   always #5 aclk = ~aclk;

   typedef struct {
      logic [31:0] d;
      logic [3:0]  s;
      logic [3:0]  k;
      logic        l;
      logic        u;
   } exp_t;

   exp_t        q[$];
   int          total = 0;
   int          bad = 0;
   int          mfill = 0;
   logic [15:0] mpkt = '0;
   logic [15:0] mdrop = '0;
   bit          merr = 0;
   bit          m_in = 0;
   bit          m_tid = 0;
   bit          last_acc = 0;
   bit          mon_on = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Reference model: apply the effect of one rising edge from the driven inputs
   task automatic model_edge();
      bit acc, pop, st;
      if (areset) begin
         mfill = 0; q.delete(); mpkt = '0; mdrop = '0;
         merr = 0; m_in = 0; last_acc = 0;
      end else begin
         acc = bus.tvalid && (mfill != DEPTH);
         pop = bus.rd_ready && (mfill != 0);
         st  = 0;
         if (acc) begin
            for (int i = 0; i < N; i++)
               if (!bus.tkeep[i] && bus.tstrb[i]) merr = 1;
            if (bus.TDEST == MY_DEST) begin
               st = (bus.tkeep != 0) || bus.tlast;
               if (m_in && (bus.TID != m_tid)) merr = 1;
               if (bus.tlast) begin
                  mpkt = mpkt + 16'd1;
                  m_in = 0;
               end else if (!m_in) begin
                  m_in  = 1;
                  m_tid = bus.TID;
               end
            end
            if (!st) mdrop = mdrop + 16'd1;
         end
         if (st) q.push_back('{d: bus.tdata, s: bus.tstrb, k: bus.tkeep, l: bus.tlast, u: bus.TUSER});
         mfill = mfill + int'(st) - int'(pop);
         last_acc = acc;
      end
   endtask

   task automatic step();
      @(posedge aclk);
      model_edge();
      #1;
   endtask

   task automatic set_beat(input logic [31:0] d, input logic [3:0] s, input logic [3:0] k,
                           input logic l, input logic tid, input logic dest, input logic u);
      bus.tvalid = 1'b1;
      bus.tdata  = d;
      bus.tstrb  = s;
      bus.tkeep  = k;
      bus.tlast  = l;
      bus.TID    = tid;
      bus.TDEST  = dest;
      bus.TUSER  = u;
   endtask

   task automatic send(input logic [31:0] d, input logic [3:0] s, input logic [3:0] k,
                       input logic l, input logic tid, input logic dest, input logic u);
      set_beat(d, s, k, l, tid, dest, u);
      for (int i = 0; i < 64; i++) begin
         step();
         if (last_acc) break;
      end
      if (!last_acc) begin
         total++;
         bad++;
         $display("FAIL send_timeout: beat %0h not accepted within 64 cycles", d);
      end
      bus.tvalid = 1'b0;
   endtask

   task automatic do_reset();
      areset     = 1'b1;
      bus.tvalid = 1'b0;
      step();
      areset     = 1'b0;
   endtask

   task automatic drain();
      bus.tvalid   = 1'b0;
      bus.rd_ready = 1'b1;
      repeat (DEPTH + 3) step();
   endtask

   always @(negedge aclk) begin
      exp_t e;
      if (mon_on) begin
         chk("fill", fill, mfill);
         chk("tready", bus.tready, (!areset && (mfill != DEPTH)));
         chk("rd_valid", bus.rd_valid, (mfill != 0));
         chk("pkt_count", pkt_count, mpkt);
         chk("drop_count", drop_count, mdrop);
         chk("proto_err", proto_err, merr);
         if (bus.rd_valid === 1'b1) begin
            if (q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL rd_head: got data %0h with nothing expected", bus.rd_data);
            end else begin
               e = q[0];
               chk("rd_data", bus.rd_data, e.d);
               chk("rd_strb", bus.rd_strb, e.s);
               chk("rd_keep", bus.rd_keep, e.k);
               chk("rd_last", bus.rd_last, e.l);
               chk("rd_user", bus.rd_user, e.u);
               if (bus.rd_ready) void'(q.pop_front());
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d;
      logic [3:0]  k, s;
      bit          cur_tid;

      bus.tvalid = 1'b0; bus.tdata = '0; bus.tstrb = '0; bus.tkeep = '0;
      bus.tlast = 1'b0; bus.TID = 1'b0; bus.TDEST = 1'b0; bus.TUSER = 1'b0;
      bus.rd_ready = 1'b0;
      areset = 1'b1;
      step();
      step();
      areset = 1'b0;
      mon_on = 1;
      chk("rst_fill", fill, 0);
      chk("rst_rd_valid", bus.rd_valid, 0);
      chk("rst_rd_data", bus.rd_data, 0);
      chk("rst_pkt", pkt_count, 0);
      chk("rst_err", proto_err, 0);

      // Single 3-beat packet with consumer always ready
      bus.rd_ready = 1'b1;
      send(32'h11111111, 4'hF, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("lat1_valid", bus.rd_valid, 1);
      chk("lat1_data", bus.rd_data, 32'h11111111);
      send(32'h22222222, 4'hF, 4'hF, 1'b0, 1'b0, 1'b1, 1'b1);
      send(32'h33333333, 4'hF, 4'hF, 1'b1, 1'b0, 1'b1, 1'b0);
      chk("pkt3_last", bus.rd_last, 1);
      step();
      step();
      chk("pkt3_count", pkt_count, 1);
      chk("pkt3_drop", drop_count, 0);

      // Fill to full, hold the ninth beat, then release one slot
      do_reset();
      bus.rd_ready = 1'b0;
      for (int i = 0; i < DEPTH; i++)
         send(32'hA000_0000 + i, 4'hF, 4'hF, 1'b0, 1'b1, 1'b1, 1'b0);
      chk("full_fill", fill, 8);
      chk("full_tready", bus.tready, 0);
      set_beat(32'hA000_0099, 4'hF, 4'hF, 1'b1, 1'b1, 1'b1, 1'b1);
      step();
      step();
      chk("held_fill", fill, 8);
      bus.rd_ready = 1'b1;
      step();
      bus.rd_ready = 1'b0;
      chk("pop_fill", fill, 7);
      chk("pop_tready", bus.tready, 1);
      step();
      bus.tvalid = 1'b0;
      chk("ninth_fill", fill, 8);
      drain();

      // Null beat, misrouted beat, then null beat carrying tlast
      do_reset();
      bus.rd_ready = 1'b0;
      send(32'hDEAD0001, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
      send(32'hDEAD0002, 4'hF, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
      send(32'hDEAD0003, 4'h0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1);
      chk("filt_drop", drop_count, 2);
      chk("filt_fill", fill, 1);
      chk("filt_keep", bus.rd_keep, 0);
      chk("filt_last", bus.rd_last, 1);
      chk("filt_pkt", pkt_count, 1);
      drain();

      // Reserved byte, then TID change inside a packet
      do_reset();
      bus.rd_ready = 1'b1;
      send(32'h0, 4'h1, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0);
      chk("rsv_err", proto_err, 1);
      do_reset();
      chk("rsv_cleared", proto_err, 0);
      send(32'h5, 4'hF, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0);
      send(32'h6, 4'hF, 4'hF, 1'b1, 1'b1, 1'b1, 1'b0);
      chk("tid_err", proto_err, 1);
      repeat (5) step();
      chk("tid_sticky", proto_err, 1);

      // Steady push+pop at fill 4 across pointer wrap
      do_reset();
      bus.rd_ready = 1'b0;
      for (int i = 0; i < 4; i++)
         send(32'hB000_0000 + i, 4'hF, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0);
      bus.rd_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         set_beat(32'hC000_0000 + i, 4'h3, 4'h3, (i == 9), 1'b0, 1'b1, i[0]);
         step();
         chk("pp_fill", fill, 4);
      end
      drain();

      // Reset in the middle of a packet with 5 entries buffered
      do_reset();
      bus.rd_ready = 1'b0;
      for (int i = 0; i < 5; i++)
         send(32'hE000_0000 + i, 4'hF, 4'hF, 1'b0, 1'b1, 1'b1, 1'b0);
      chk("mid_fill", fill, 5);
      do_reset();
      chk("mrst_fill", fill, 0);
      chk("mrst_valid", bus.rd_valid, 0);
      chk("mrst_pkt", pkt_count, 0);
      chk("mrst_drop", drop_count, 0);
      send(32'hF00D_F00D, 4'hF, 4'hF, 1'b1, 1'b0, 1'b1, 1'b0);
      chk("mrst_pkt1", pkt_count, 1);
      chk("mrst_noerr", proto_err, 0);
      drain();

      // Random traffic, inputs held until accepted
      do_reset();
      cur_tid = 0;
      for (int c = 0; c < 900; c++) begin
         if (!bus.tvalid || last_acc) begin
            d = $urandom;
            k = 4'($urandom_range(0, 15));
            s = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(0, 15)) : (k & 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 15) == 0) cur_tid = ~cur_tid;
            set_beat(d, s, k, ($urandom_range(0, 3) == 0), cur_tid,
                     ($urandom_range(0, 4) != 0), 1'($urandom_range(0, 1)));
            bus.tvalid = ($urandom_range(0, 3) != 0);
         end
         bus.rd_ready = (c < 450) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
         areset = ($urandom_range(0, 299) == 0);
         step();
      end
      areset = 1'b0;
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
